// File: rtl/max_reduce_pkg.sv
// Shared definitions for the streaming max-reduction controller.
//   DEF_WIDTH / DEF_CNT_W : default operand width and element-counter width
//   state_t               : controller state encoding
package max_reduce_pkg;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gt_int_nbit.sv
// Combinational signed greater-than comparator over two's-complement operands.
//   a : left operand
//   b : right operand
//   y : 1 when a > b (signed)
module gt_int_nbit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             y
);

    assign y = $signed(a) > $signed(b);

endmodule

// File: rtl/max_reduce_int64_ctrl.sv
// Streaming max-reduction controller: runs one shared signed comparator over a
// packet of cfg_len operands. It returns the packet maximum and the index of the
// first element that holds that maximum.
//   clk, rst             : clock, asynchronous active-high reset
//   start, cfg_len       : packet request and element count; sampled in IDLE only
//   busy, err_len0       : not-idle flag; one-cycle pulse for a zero-length request
//   in_valid/in_ready    : operand stream handshake, carrying in_data
//   out_valid/out_ready  : result handshake, carrying out_max and out_idx
module max_reduce_int64_ctrl
    import max_reduce_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_len,
    output logic             busy,
    output logic             err_len0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_idx
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] idx;
    logic             gt;
    logic             accept;
    logic             last_beat;
    logic             start_ok;
    logic             start_zero;

    // The one comparator in the block: the new operand against the running maximum.
    gt_int_nbit #(.WIDTH(WIDTH)) u_gt (
        .a (in_data),
        .b (acc),
        .y (gt)
    );

    assign accept     = in_valid && (state == ACCUM);
    assign last_beat  = (cnt == len - CNT_W'(1));
    assign start_ok   = (state == IDLE) && start && (cfg_len != '0);
    assign start_zero = (state == IDLE) && start && (cfg_len == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nx = ACCUM;
            end
            ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath. The first beat seeds the accumulator. Later beats replace it only
    // when strictly greater, so a tie keeps the earlier index. cnt holds at len-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            cnt      <= '0;
            acc      <= '0;
            idx      <= '0;
            err_len0 <= 1'b0;
        end else begin
            err_len0 <= start_zero;
            if (start_ok) begin
                len <= cfg_len;
                cnt <= '0;
            end
            if (accept) begin
                if (cnt == '0) begin
                    acc <= in_data;
                    idx <= '0;
                end else if (gt) begin
                    acc <= in_data;
                    idx <= cnt;
                end
                if (!last_beat) cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_max = acc;
    assign out_idx = idx;

endmodule
